alarm_sequencer: RTL

Clocked controller for the wall-clock alarm feature: owns the stored alarm time and sequences set, arm, ring, and snooze. It watches the BCD time from the clock counter and drives the alarm LEDs. It sits between the debounced button/switch front end and the LED/display outputs, alongside the time-keeping counter.

---
 rtl/clock_alarm_pkg.sv | 10 +
 rtl/bcd_inc.sv | 16 +
 rtl/alarm_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/clock_alarm_pkg.sv
// clock_alarm_pkg: shared state enum, BCD limits, default timing and LED constants for the alarm block
package clock_alarm_pkg;
  typedef enum logic [2:0] {IDLE, ARMED, RINGING, SNOOZE, SET} state_e;
  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX = 59;
  localparam int DEF_BLINK_TOGGLES = 10;
  localparam int DEF_SNOOZE_MIN = 5;
  localparam logic [5:0] LED_ALL_ON = 6'b111111;
  localparam logic [5:0] LED_OFF = 6'b000000;
endpackage

// File: rtl/bcd_inc.sv
// bcd_inc: two-digit BCD increment that wraps to 00 after LIMIT
module bcd_inc #(
  parameter int LIMIT = 59
) (
  input  logic [3:0] d1_i,
  input  logic [3:0] d0_i,
  output logic [3:0] q1_o,
  output logic [3:0] q0_o
);
  localparam logic [3:0] L1 = 4'(LIMIT / 10);
  localparam logic [3:0] L0 = 4'(LIMIT % 10);
  logic wrap;
  assign wrap = (d1_i == L1) && (d0_i == L0);
  assign q1_o = wrap ? 4'd0 : (d0_i == 4'd9) ? d1_i + 4'd1 : d1_i;
  assign q0_o = wrap ? 4'd0 : (d0_i == 4'd9) ? 4'd0 : d0_i + 4'd1;
endmodule

// File: rtl/alarm_sequencer.sv
// alarm_sequencer: stores the alarm time and sequences set/arm/ring/snooze, driving the alarm LEDs.
// Optional snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_sequencer
  import clock_alarm_pkg::*;
#(
  parameter int BLINK_TOGGLES = DEF_BLINK_TOGGLES,
  parameter int SNOOZE_MIN = DEF_SNOOZE_MIN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       minute_tick,
  input  logic [3:0] time_h1,
  input  logic [3:0] time_h0,
  input  logic [3:0] time_m1,
  input  logic [3:0] time_m0,
  input  logic       alarm_en,
  input  logic       set_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_snooze,
  input  logic       btn_stop,
  output logic [3:0] alarm_h1,
  output logic [3:0] alarm_h0,
  output logic [3:0] alarm_m1,
  output logic [3:0] alarm_m0,
  output logic [5:0] alarm_led,
  output logic       ringing,
  output logic       snoozing
);
  state_e state_q, state_d;
  logic [5:0] led_q, led_d, cnt_q, cnt_d;
  logic [3:0] h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic [3:0] hi1, hi0, mi1, mi0;
  logic mt_q, match;
  bcd_inc #(.LIMIT(HOUR_MAX)) u_hour (.d1_i(h1_q), .d0_i(h0_q), .q1_o(hi1), .q0_o(hi0));
  bcd_inc #(.LIMIT(MIN_MAX)) u_min (.d1_i(m1_q), .d0_i(m0_q), .q1_o(mi1), .q0_o(mi0));
  // compare on the delayed tick so the time inputs have settled on the new minute
  assign match = mt_q && ({time_h1, time_h0, time_m1, time_m0} == {h1_q, h0_q, m1_q, m0_q});
`ifdef ALARM_SNOOZE_EN
  logic [3:0] snz_q, snz_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snz_q <= '0;
    else snz_q <= snz_d;
  end
  assign snoozing = (state_q == SNOOZE);
`else
  logic unused_snooze;
  assign unused_snooze = btn_snooze | (SNOOZE_MIN == 0);
  assign snoozing = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      led_q <= LED_OFF;
      cnt_q <= '0;
      mt_q <= 1'b0;
      {h1_q, h0_q, m1_q, m0_q} <= '0;
    end else begin
      state_q <= state_d;
      led_q <= led_d;
      cnt_q <= cnt_d;
      mt_q <= minute_tick;
      {h1_q, h0_q, m1_q, m0_q} <= {h1_d, h0_d, m1_d, m0_d};
    end
  end
  always_comb begin
    state_d = state_q;
    led_d = led_q;
    cnt_d = cnt_q;
    {h1_d, h0_d, m1_d, m0_d} = {h1_q, h0_q, m1_q, m0_q};
`ifdef ALARM_SNOOZE_EN
    snz_d = snz_q;
`endif
    if (set_mode) begin
      state_d = SET;
      led_d = LED_ALL_ON;
      cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
      snz_d = '0;
`endif
      if (state_q == SET && btn_hour) {h1_d, h0_d} = {hi1, hi0};
      if (state_q == SET && btn_min) {m1_d, m0_d} = {mi1, mi0};
    end else if (state_q == SET) begin
      state_d = alarm_en ? ARMED : IDLE;
      led_d = LED_OFF;
    end else if (!alarm_en) begin
      state_d = IDLE;
      led_d = LED_OFF;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: state_d = ARMED;
        ARMED: if (match) begin
          state_d = RINGING;
          led_d = LED_ALL_ON;
          cnt_d = '0;
        end
        RINGING: if (btn_stop || (tick_1hz && cnt_q + 6'd1 == 6'(BLINK_TOGGLES))) begin
          state_d = ARMED;
          led_d = LED_OFF;
`ifdef ALARM_SNOOZE_EN
        end else if (btn_snooze) begin
          state_d = SNOOZE;
          led_d = LED_OFF;
          snz_d = 4'(SNOOZE_MIN);
`endif
        end else if (tick_1hz) begin
          led_d = ~led_q;
          cnt_d = cnt_q + 6'd1;
        end
`ifdef ALARM_SNOOZE_EN
        SNOOZE: if (btn_stop) begin
          state_d = ARMED;
          led_d = LED_OFF;
        end else if (minute_tick) begin
          snz_d = snz_q - 4'd1;
          if (snz_q == 4'd1) begin
            state_d = RINGING;
            led_d = LED_ALL_ON;
            cnt_d = '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end
  assign {alarm_h1, alarm_h0, alarm_m1, alarm_m0} = {h1_q, h0_q, m1_q, m0_q};
  assign alarm_led = led_q;
  assign ringing = (state_q == RINGING);
endmodule
